// File: rtl/mat_d_reader.sv
// mat_d_reader: streams an M x R matrix out of a BRAM in row-major order.
// Reads are credit-limited against a two-entry output buffer so the stream
// can be back-pressured with d_ready without losing or duplicating data.
module mat_d_reader #(
    parameter int M    = 3,
    parameter int R    = 5,
    parameter int BASE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        wrD_done,
    output logic [7:0]  addrbD,
    input  logic [31:0] doutbD,
    output logic [31:0] d_data,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [3:0]  d_row,
    output logic [3:0]  d_col,
    output logic        d_last,
    output logic        busy,
    output logic        rd_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_WR,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state_q;

    // next element to request
    logic [3:0]  row_q, col_q;
    logic [7:0]  lin_q;
    logic [7:0]  addr_q;

    // read in flight (data appears on doutbD this cycle)
    logic        fl_q;
    logic [3:0]  fl_row_q, fl_col_q;
    logic        fl_last_q;

    // buffer head (drives the stream outputs) and tail entry
    logic        h_vld_q, t_vld_q;
    logic [31:0] h_data_q, t_data_q;
    logic [3:0]  h_row_q, h_col_q, t_row_q, t_col_q;
    logic        h_last_q, t_last_q;

    logic        pop;
    logic        issue;
    logic        last_pos;
    logic [1:0]  occ_after;
    logic [1:0]  credit_used;
    logic [7:0]  addr_d;

    // Credit counts occupancy after this edge's pop, so a pop and a new
    // issue can overlap and a ready consumer sees one element per cycle.
    always_comb begin
        pop         = h_vld_q & d_ready;
        occ_after   = {1'b0, h_vld_q} + {1'b0, t_vld_q} - {1'b0, pop};
        credit_used = occ_after + {1'b0, fl_q};
        issue       = (state_q == S_READ) && (credit_used < 2'd2);
        last_pos    = (row_q == 4'(M - 1)) && (col_q == 4'(R - 1));
        addr_d      = 8'(BASE) + lin_q;
        // The address is presented in the issuing cycle so the BRAM returns
        // data in the next cycle; otherwise it holds the last issued value.
        addrbD      = issue ? addr_d : addr_q;
    end

    // Control FSM, read issue, address counters and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            lin_q     <= '0;
            addr_q    <= '0;
            fl_q      <= 1'b0;
            fl_row_q  <= '0;
            fl_col_q  <= '0;
            fl_last_q <= 1'b0;
            busy      <= 1'b0;
            rd_done   <= 1'b0;
        end else begin
            fl_q <= issue;
            if (issue) begin
                addr_q    <= addr_d;
                fl_row_q  <= row_q;
                fl_col_q  <= col_q;
                fl_last_q <= last_pos;
                lin_q     <= lin_q + 8'd1;
                if (col_q == 4'(R - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + 4'd1;
                end else begin
                    col_q <= col_q + 4'd1;
                end
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_WAIT_WR;
                        busy    <= 1'b1;
                        rd_done <= 1'b0;
                        row_q   <= '0;
                        col_q   <= '0;
                        lin_q   <= '0;
                    end
                end
                S_WAIT_WR: begin
                    if (wrD_done) begin
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    if (issue && last_pos) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && h_last_q) begin
                        state_q <= S_DONE;
                        busy    <= 1'b0;
                        rd_done <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                    rd_done <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry output buffer: returning data enters the head when it is
    // free (or being popped with no tail), else the tail
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_vld_q  <= 1'b0;
            h_data_q <= '0;
            h_row_q  <= '0;
            h_col_q  <= '0;
            h_last_q <= 1'b0;
            t_vld_q  <= 1'b0;
            t_data_q <= '0;
            t_row_q  <= '0;
            t_col_q  <= '0;
            t_last_q <= 1'b0;
        end else if (pop) begin
            if (t_vld_q) begin
                h_data_q <= t_data_q;
                h_row_q  <= t_row_q;
                h_col_q  <= t_col_q;
                h_last_q <= t_last_q;
                if (fl_q) begin
                    t_data_q <= doutbD;
                    t_row_q  <= fl_row_q;
                    t_col_q  <= fl_col_q;
                    t_last_q <= fl_last_q;
                end else begin
                    t_vld_q <= 1'b0;
                end
            end else if (fl_q) begin
                h_data_q <= doutbD;
                h_row_q  <= fl_row_q;
                h_col_q  <= fl_col_q;
                h_last_q <= fl_last_q;
            end else begin
                h_vld_q <= 1'b0;
            end
        end else if (fl_q) begin
            if (!h_vld_q) begin
                h_vld_q  <= 1'b1;
                h_data_q <= doutbD;
                h_row_q  <= fl_row_q;
                h_col_q  <= fl_col_q;
                h_last_q <= fl_last_q;
            end else begin
                t_vld_q  <= 1'b1;
                t_data_q <= doutbD;
                t_row_q  <= fl_row_q;
                t_col_q  <= fl_col_q;
                t_last_q <= fl_last_q;
            end
        end
    end

    assign d_valid = h_vld_q;
    assign d_data  = h_data_q;
    assign d_row   = h_row_q;
    assign d_col   = h_col_q;
    assign d_last  = h_last_q;

endmodule

// File: tb/tb_mat_d_reader.sv
// Testbench for mat_d_reader: 3x5 matrix at BASE=1 holding 15,25,...,155.
module tb_mat_d_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        wrD_done;
    logic [7:0]  addrbD;
    logic [31:0] doutbD;
    logic [31:0] d_data;
    logic        d_valid;
    logic        d_ready;
    logic [3:0]  d_row, d_col;
    logic        d_last;
    logic        busy;
    logic        rd_done;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  row;
        logic [3:0]  col;
        logic [31:0] data;
        logic        last;
    } vec_t;

    vec_t        exp_tab [15];
    logic [31:0] mem [256];

    mat_d_reader #(.M(3), .R(5), .BASE(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .wrD_done (wrD_done),
        .addrbD   (addrbD),
        .doutbD   (doutbD),
        .d_data   (d_data),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_row    (d_row),
        .d_col    (d_col),
        .d_last   (d_last),
        .busy     (busy),
        .rd_done  (rd_done)
    );

    always #5 clk = ~clk;

    // synchronous-read BRAM model
    always @(posedge clk) doutbD <= mem[addrbD];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " addrbD"},  32'(addrbD),  32'd0);
        chk({tag, " d_data"},  d_data,       32'd0);
        chk({tag, " d_valid"}, 32'(d_valid), 32'd0);
        chk({tag, " d_row"},   32'(d_row),   32'd0);
        chk({tag, " d_col"},   32'(d_col),   32'd0);
        chk({tag, " d_last"},  32'(d_last),  32'd0);
        chk({tag, " busy"},    32'(busy),    32'd0);
        chk({tag, " rd_done"}, 32'(rd_done), 32'd0);
    endtask

    // mode 0: ready high; 1: ready toggles; 2: ready low for stall_n cycles.
    // wait_n > 0 holds wrD_done low that many cycles after start.
    task automatic run_stream(input int mode, input int stall_n, input int wait_n,
                              input bit drop_wr, input int lat_exp, input int stop_after,
                              input logic [7:0] hold_addr);
        int k = 0;
        int cyc = 0;
        int first = -1;
        int lastc = -1;
        bit held = 1'b0;
        logic [31:0] hd;
        logic [3:0]  hr, hc;
        logic        hl;
        @(negedge clk);
        if (wait_n > 0) wrD_done = 1'b0;
        start = 1'b1;
        while (k < 15 && cyc < 400 && !(stop_after > 0 && k >= stop_after)) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 1) begin
                chk("busy after start", 32'(busy), 32'd1);
                chk("rd_done cleared", 32'(rd_done), 32'd0);
            end
            if (wait_n > 0 && cyc <= wait_n) begin
                chk("wait busy", 32'(busy), 32'd1);
                chk("wait d_valid", 32'(d_valid), 32'd0);
                chk("wait addrbD", 32'(addrbD), 32'(hold_addr));
                if (cyc == wait_n) wrD_done = 1'b1;
            end
            if (held) begin
                chk("stall d_valid", 32'(d_valid), 32'd1);
                chk("stall d_data", d_data, hd);
                chk("stall d_row", 32'(d_row), 32'(hr));
                chk("stall d_col", 32'(d_col), 32'(hc));
                chk("stall d_last", 32'(d_last), 32'(hl));
            end
            case (mode)
                0:       d_ready = 1'b1;
                1:       d_ready = cyc[0];
                default: d_ready = (cyc > stall_n);
            endcase
            if (mode == 2 && cyc == stall_n) begin
                chk("stall reads issued", 32'(addrbD), 32'd2);
                chk("stall head data", d_data, 32'd15);
            end
            if (d_valid && first < 0) begin
                first = cyc;
                if (lat_exp > 0) chk("first valid latency", first, lat_exp);
            end
            if (d_valid && d_ready) begin
                chk("elem data", d_data, exp_tab[k].data);
                chk("elem row", 32'(d_row), 32'(exp_tab[k].row));
                chk("elem col", 32'(d_col), 32'(exp_tab[k].col));
                chk("elem last", 32'(d_last), 32'(exp_tab[k].last));
                k++;
                lastc = cyc;
                if (drop_wr) wrD_done = 1'b0;
            end
            held = d_valid && !d_ready;
            hd = d_data;
            hr = d_row;
            hc = d_col;
            hl = d_last;
        end
        if (stop_after == 0) begin
            chk("element count", k, 15);
            if (mode == 0) chk("throughput span", lastc - first, 14);
            @(negedge clk);
            @(negedge clk);
            chk("done rd_done", 32'(rd_done), 32'd1);
            chk("done busy", 32'(busy), 32'd0);
            chk("done d_valid", 32'(d_valid), 32'd0);
            chk("done addrbD hold", 32'(addrbD), 32'd15);
        end
    endtask

    initial begin
        exp_tab[0]  = '{4'd0, 4'd0, 32'd15,  1'b0};
        exp_tab[1]  = '{4'd0, 4'd1, 32'd25,  1'b0};
        exp_tab[2]  = '{4'd0, 4'd2, 32'd35,  1'b0};
        exp_tab[3]  = '{4'd0, 4'd3, 32'd45,  1'b0};
        exp_tab[4]  = '{4'd0, 4'd4, 32'd55,  1'b0};
        exp_tab[5]  = '{4'd1, 4'd0, 32'd65,  1'b0};
        exp_tab[6]  = '{4'd1, 4'd1, 32'd75,  1'b0};
        exp_tab[7]  = '{4'd1, 4'd2, 32'd85,  1'b0};
        exp_tab[8]  = '{4'd1, 4'd3, 32'd95,  1'b0};
        exp_tab[9]  = '{4'd1, 4'd4, 32'd105, 1'b0};
        exp_tab[10] = '{4'd2, 4'd0, 32'd115, 1'b0};
        exp_tab[11] = '{4'd2, 4'd1, 32'd125, 1'b0};
        exp_tab[12] = '{4'd2, 4'd2, 32'd135, 1'b0};
        exp_tab[13] = '{4'd2, 4'd3, 32'd145, 1'b0};
        exp_tab[14] = '{4'd2, 4'd4, 32'd155, 1'b1};

        for (int a = 0; a < 256; a++) mem[a] = 32'd0;
        for (int a = 1; a <= 15; a++) mem[a] = 32'(10 * a + 5);

        reset    = 1'b1;
        start    = 1'b0;
        wrD_done = 1'b0;
        d_ready  = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        // wrD_done low for 20 cycles, then stream (READ entered the edge after)
        run_stream(0, 0, 20, 1'b0, 23, 0, 8'd0);

        // writer already complete: full pass with d_ready high
        wrD_done = 1'b1;
        run_stream(0, 0, 0, 1'b0, 4, 0, 8'd0);

        // second start from DONE repeats the identical stream
        run_stream(0, 0, 0, 1'b0, 4, 0, 8'd0);

        // consumer stalled through READ, then released
        run_stream(2, 30, 0, 1'b0, 4, 0, 8'd0);

        // d_ready toggling, wrD_done dropped mid-pass
        run_stream(1, 0, 0, 1'b1, 4, 0, 8'd0);
        wrD_done = 1'b1;

        // reset after 7 transfers, then a fresh pass from (0,0)
        run_stream(0, 0, 0, 1'b0, 4, 7, 8'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_reset_vals("midpass reset");
        @(negedge clk);
        reset = 1'b0;
        run_stream(0, 0, 0, 1'b0, 4, 0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
